piso_shifter: RTL and testbench



---
 rtl/piso_pkg.sv | 15 +
 rtl/mux2.sv | 25 ++
 rtl/piso_shifter.sv | 110 +++++++++++
 tb/tb_piso_shifter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out shifter.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } piso_state_t;

  // Bit-counter width for a given word width (at least one bit).
  function automatic int piso_cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mux2.sv
// Gate-level 2:1 mux built from three NAND levels: not_sel -> d0_nand -> final_nand.
// nand_tpd is the NAND2 delay of the target cell; it has no effect on the logic function.
module mux2 #(
  parameter int nand_tpd = 1
) (
  input  logic sel,
  input  logic d0,
  input  logic d1,
  output logic y
);

  logic w_not_sel;
  logic w_d0_nand;
  logic w_d1_nand;

  assign w_not_sel = ~(sel & sel);
  assign w_d0_nand = ~(d0 & w_not_sel);
  assign w_d1_nand = ~(d1 & sel);
  assign y         = ~(w_d0_nand & w_d1_nand);

  if (nand_tpd < 0) begin : g_bad_tpd
    $error("mux2: nand_tpd must be non-negative");
  end

endmodule

// File: rtl/piso_shifter.sv
// Valid/ready word in, one bit per clock out (LSB first); each sr bit loads through a mux2.
// Optional macro PISO_PARITY_EN appends an even-parity bit as an extra final cycle.
// IDLE: no frame | SHIFT: data bit r_cnt on ser_out | PARITY: parity bit on ser_out
module piso_shifter
  import piso_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int nand_tpd = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last
);

  localparam int            CW       = piso_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  piso_state_t      r_state;
  piso_state_t      w_state_nxt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_nxt;
  logic [WIDTH-1:0] w_shift;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_accept;
  logic             w_last_bit;

  assign w_accept   = load_valid && load_ready;
  assign w_last_bit = (r_state == SHIFT) && (r_cnt == LAST_CNT);
  assign w_shift    = {1'b0, r_sr[WIDTH-1:1]};

  // Outside SHIFT the register is already all-zero, so shifting unconditionally is harmless.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    mux2 #(.nand_tpd(nand_tpd)) u_mux (
      .sel(w_accept),
      .d0 (w_shift[gi]),
      .d1 (load_data[gi]),
      .y  (w_sr_nxt[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_accept) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (r_cnt == LAST_CNT) begin
          w_cnt_nxt = '0;
`ifdef PISO_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_state_nxt = w_accept ? SHIFT : IDLE;
`endif
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      PARITY: begin
        w_cnt_nxt   = '0;
        w_state_nxt = w_accept ? SHIFT : IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

`ifdef PISO_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_par <= 1'b0;
    else if (w_accept) r_par <= ^load_data;
  end

  assign ser_last = (r_state == PARITY);
  assign ser_out  = (r_state == PARITY) ? r_par : ((r_state == SHIFT) && r_sr[0]);
`else
  assign ser_last = w_last_bit;
  assign ser_out  = (r_state == SHIFT) && r_sr[0];
`endif

  assign ser_valid  = (r_state == SHIFT) || (r_state == PARITY);
  assign ser_first  = (r_state == SHIFT) && (r_cnt == '0);
  assign load_ready = (r_state == IDLE) || ser_last;

endmodule

// File: tb/tb_piso_shifter.sv
// Bench for piso_shifter: a queue of pending serial symbols predicts every output cycle,
// with directed frames pinning literal bit patterns. Honours PISO_PARITY_EN if defined.
module tb_piso_shifter;

`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int WIDTH = 8;
  localparam int FRAME = WIDTH + PAR;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic             load_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_first;
  logic             ser_last;

  int n_checks = 0;
  int n_errors = 0;

  piso_shifter #(.WIDTH(WIDTH), .nand_tpd(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_first (ser_first),
    .ser_last  (ser_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue holds the symbols still to appear on the serial port.
  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } sym_t;

  sym_t q[$];
  logic m_rdy;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
    end else begin
      m_rdy = 1'b1;
      if (q.size() > 0) begin
        m_rdy = q[0].l;
        void'(q.pop_front());
      end
      if (load_valid && m_rdy) begin
        for (int i = 0; i < WIDTH; i++)
          q.push_back('{b: load_data[i], f: (i == 0), l: (PAR == 0) && (i == WIDTH - 1)});
`ifdef PISO_PARITY_EN
        q.push_back('{b: ^load_data, f: 1'b0, l: 1'b1});
`endif
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (q.size() == 0) begin
      check("idle_valid", ser_valid, 0);
      check("idle_out",   ser_out,   0);
      check("idle_first", ser_first, 0);
      check("idle_last",  ser_last,  0);
      check("idle_ready", load_ready, 1);
    end else begin
      check("frm_valid", ser_valid, 1);
      check("frm_out",   ser_out,   q[0].b);
      check("frm_first", ser_first, q[0].f);
      check("frm_last",  ser_last,  q[0].l);
      check("frm_ready", load_ready, q[0].l);
    end
  end

  logic [31:0] cap;
  logic [31:0] vld;
  logic [31:0] fst;
  int          cnt;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    check("rst_ready", load_ready, 1);
    check("rst_valid", ser_valid, 0);
    check("rst_out",   ser_out,   0);
    check("rst_first", ser_first, 0);
    check("rst_last",  ser_last,  0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame 8'hA5
    load_valid = 1'b1; load_data = 8'hA5;
    @(negedge clk);
    load_valid = 1'b0; load_data = 8'h3E;
    cap = '0;
    for (int k = 0; k < FRAME; k++) begin
      cap[k] = ser_out;
      check("a5_first", ser_first, (k == 0));
      check("a5_last",  ser_last,  (k == FRAME - 1));
      @(negedge clk);
    end
    check("a5_bits",  cap[7:0], 8'hA5);
    check("a5_after", ser_valid, 0);

    // Back-to-back 8'hFF then 8'h00
    repeat (2) @(negedge clk);
    load_valid = 1'b1; load_data = 8'hFF;
    @(negedge clk);
    cap = '0; vld = '0; fst = '0;
    for (int c = 0; c <= 2 * FRAME; c++) begin
      if (c == 0) load_data = 8'h00;
      if (c == FRAME) load_valid = 1'b0;
      cap[c] = ser_out; vld[c] = ser_valid; fst[c] = ser_first;
      @(negedge clk);
    end
    cnt = 0;
    for (int c = 0; c < 2 * FRAME; c++) cnt += int'(vld[c]);
    check("b2b_valid_cnt", cnt, 2 * FRAME);
    check("b2b_valid_end", vld[2*FRAME], 0);
    check("b2b_first_pos", fst, (32'h1 | (32'h1 << FRAME)));
    check("b2b_word0", cap[7:0], 8'hFF);
    check("b2b_word1", (cap >> FRAME) & 32'hFF, 8'h00);

    // Busy ignore: 8'h55 offered during bit 3, taken on the final cycle
    repeat (2) @(negedge clk);
    load_valid = 1'b1; load_data = 8'h96;
    @(negedge clk);
    load_valid = 1'b0;
    cap = '0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      if (c == 3) begin
        load_valid = 1'b1; load_data = 8'h55;
        check("busy_ready_lo", load_ready, 0);
      end
      if (c > 3 && c < FRAME - 1) load_data = WIDTH'($urandom);
      if (c == FRAME - 1) begin
        load_data = 8'h55;
        check("busy_ready_hi", load_ready, 1);
      end
      if (c == FRAME) load_valid = 1'b0;
      cap[c] = ser_out;
      @(negedge clk);
    end
    check("busy_word0", cap[7:0], 8'h96);
    check("busy_word1", (cap >> FRAME) & 32'hFF, 8'h55);

    // Mid-frame reset during bit 3 of 8'h3C
    repeat (2) @(negedge clk);
    load_valid = 1'b1; load_data = 8'h3C;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mrst_pre_valid", ser_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_valid", ser_valid, 0);
    check("mrst_out",   ser_out,   0);
    check("mrst_ready", load_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_valid = 1'b1; load_data = 8'h01;
    @(negedge clk);
    load_valid = 1'b0;
    cap = '0;
    for (int k = 0; k < FRAME; k++) begin
      cap[k] = ser_out;
      @(negedge clk);
    end
    check("mrst_next", cap[7:0], 8'h01);

    // 8'h07: odd population, so the parity bit (when present) is 1
    load_valid = 1'b1; load_data = 8'h07;
    @(negedge clk);
    load_valid = 1'b0;
    cap = '0;
    for (int k = 0; k < FRAME; k++) begin
      cap[k] = ser_out;
      check("p07_last", ser_last, (k == FRAME - 1));
      @(negedge clk);
    end
    check("p07_bits", cap, (32'h07 | (32'(PAR) << 8)));
    check("p07_after", ser_valid, 0);

    // Random traffic with occasional async resets, checked by the model
    for (int n = 0; n < 800; n++) begin
      @(posedge clk);
      #2;
      rst_n      = ($urandom_range(0, 149) != 0);
      load_valid = ($urandom_range(0, 3) != 0);
      load_data  = WIDTH'($urandom);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1; load_valid = 1'b0;
    repeat (2 * FRAME) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
